alu_seq: RTL and testbench

//  Parametrised multi-cycle ALU for the calculator datapath, sitting between the

---
 rtl/alu_seq.sv | 200 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Multi-cycle ALU: add/sub in 1 EXEC cycle, shift-add mul / restoring div in WIDTH cycles, done 1 cycle after EXEC.
// No queueing: parser_done_i is accepted only while not busy (IDLE or DONE) and is silently dropped otherwise.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             data_type_i,
    input  logic [1:0]       op_i,
    input  logic             parser_done_i,
    output logic             busy_o,
    output logic             alu_done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] rem_o,
    output logic             overflow_o,
    output logic             div_by_zero_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;
    localparam int         CW     = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic                 dt_q, dt_d;
    logic [1:0]           op_q, op_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic                 ovf_q, ovf_d;
    logic                 dbz_q, dbz_d;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic is_signed);
        return (is_signed && x[WIDTH-1]) ? -x : x;
    endfunction

    logic                 start;
    logic [WIDTH-1:0]     mag_ai, mag_bi, mag_aq, mag_bq;
    logic                 sign_a, sign_b, neg_res;
    logic [WIDTH-1:0]     acc_hi, acc_lo;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_nxt, prod_fin;
    logic [WIDTH:0]       prod_top;
    logic [WIDTH:0]       div_shift, div_diff;
    logic [2*WIDTH-1:0]   div_nxt;
    logic [WIDTH-1:0]     quot_fin, rem_fin;
    logic [WIDTH:0]       add_full, sub_full;
    logic                 is_dz, is_min_neg1, last;

    assign start  = parser_done_i && (state_q != S_EXEC);
    assign mag_ai = mag(a_i, data_type_i);
    assign mag_bi = mag(b_i, data_type_i);
    assign mag_aq = mag(a_q, dt_q);
    assign mag_bq = mag(b_q, dt_q);
    assign sign_a  = dt_q && a_q[WIDTH-1];
    assign sign_b  = dt_q && b_q[WIDTH-1];
    assign neg_res = sign_a ^ sign_b;
    assign acc_hi  = acc_q[2*WIDTH-1:WIDTH];
    assign acc_lo  = acc_q[WIDTH-1:0];

    // Multiply step: acc = {partial product, remaining multiplier bits}, shifted right each cycle.
    assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_aq} : {(WIDTH+1){1'b0}});
    assign mul_nxt  = {mul_sum, acc_lo[WIDTH-1:1]};
    assign prod_fin = neg_res ? -mul_nxt : mul_nxt;
    assign prod_top = prod_fin[2*WIDTH-1:WIDTH-1];

    // Divide step: acc = {partial remainder, dividend bits / quotient bits shifting in}.
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, mag_bq};
    assign div_nxt   = {(div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                        acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
    assign quot_fin  = neg_res ? -div_nxt[WIDTH-1:0] : div_nxt[WIDTH-1:0];
    assign rem_fin   = sign_a ? -div_nxt[2*WIDTH-1:WIDTH] : div_nxt[2*WIDTH-1:WIDTH];

    assign add_full    = {1'b0, a_q} + {1'b0, b_q};
    assign sub_full    = {1'b0, a_q} - {1'b0, b_q};
    assign is_dz       = (op_q == OP_DIV) && (b_q == '0);
    assign is_min_neg1 = dt_q && (a_q == MIN_VAL) && (&b_q);
    assign last        = !op_q[1] || is_dz || (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        dt_d     = dt_q;
        op_d     = op_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        rem_d    = rem_q;
        ovf_d    = ovf_q;
        dbz_d    = dbz_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_EXEC;
                    a_d     = a_i;
                    b_d     = b_i;
                    dt_d    = data_type_i;
                    op_d    = op_i;
                    cnt_d   = '0;
                    acc_d   = {{WIDTH{1'b0}}, (op_i == OP_MUL) ? mag_bi : mag_ai};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                acc_d = (op_q == OP_MUL) ? mul_nxt : div_nxt;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    state_d = S_DONE;
                    rem_d   = '0;
                    dbz_d   = 1'b0;
                    case (op_q)
                        OP_ADD: begin
                            result_d = add_full[WIDTH-1:0];
                            ovf_d    = dt_q ? ((a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                               (add_full[WIDTH-1] != a_q[WIDTH-1]))
                                            : add_full[WIDTH];
                        end
                        OP_SUB: begin
                            result_d = sub_full[WIDTH-1:0];
                            ovf_d    = dt_q ? ((a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                               (sub_full[WIDTH-1] != a_q[WIDTH-1]))
                                            : sub_full[WIDTH];
                        end
                        OP_MUL: begin
                            result_d = prod_fin[WIDTH-1:0];
                            ovf_d    = dt_q ? !((&prod_top) || !(|prod_top))
                                            : (|prod_fin[2*WIDTH-1:WIDTH]);
                        end
                        default: begin
                            if (is_dz) begin
                                result_d = '1;
                                rem_d    = a_q;
                                ovf_d    = 1'b0;
                                dbz_d    = 1'b1;
                            end else begin
                                result_d = quot_fin;
                                rem_d    = rem_fin;
                                ovf_d    = is_min_neg1;
                            end
                        end
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            dt_q     <= 1'b0;
            op_q     <= OP_ADD;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            rem_q    <= '0;
            ovf_q    <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            dt_q     <= dt_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            ovf_q    <= ovf_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy_o        = (state_q == S_EXEC);
    assign alu_done_o    = (state_q == S_DONE);
    assign result_o      = result_q;
    assign rem_o         = rem_q;
    assign overflow_o    = ovf_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=8): vector table through a scoreboard, plus hand-written multi-cycle corner cases.
module tb_alu_seq;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         data_type = 1'b0;
    logic [1:0]   op = 2'd0;
    logic         parser_done = 1'b0;
    logic         busy, alu_done, overflow, div_by_zero;
    logic [W-1:0] result, rem;

    alu_seq #(.WIDTH(W)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .a_i           (a),
        .b_i           (b),
        .data_type_i   (data_type),
        .op_i          (op),
        .parser_done_i (parser_done),
        .busy_o        (busy),
        .alu_done_o    (alu_done),
        .result_o      (result),
        .rem_o         (rem),
        .overflow_o    (overflow),
        .div_by_zero_o (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         dt;
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [W-1:0] rem;
        logic         ovf;
        logic         dbz;
        int           lat;
    } vec_t;

    typedef struct {
        vec_t v;
        int   e0;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[16];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   done_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Latency is counted as the edge, relative to the accepting edge E0, at which alu_done is captured.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && alu_done) begin
            done_seen++;
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_alu_done at cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                chk("result", result, e.v.res);
                chk("rem", rem, e.v.rem);
                chk("overflow", overflow, e.v.ovf);
                chk("div_by_zero", div_by_zero, e.v.dbz);
                chk("latency", cyc - e.e0 + 1, e.v.lat);
                chk("busy_at_done", busy, 1'b0);
            end
        end
    end

    task automatic start_op(input vec_t v);
        a = v.a;
        b = v.b;
        op = v.op;
        data_type = v.dt;
        parser_done = 1'b1;
        sb.push_back('{v, cyc + 1});
        @(negedge clk);
        parser_done = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int busy_cnt);
        busy_cnt = 0;
        for (int i = 0; i < budget; i++) begin
            if (alu_done) return;
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        chk("timeout_alu_done", 32'd0, 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int bc;
        start_op(v);
        wait_done(40, bc);
        chk("busy_cycles", bc, v.lat - 1);
        @(negedge clk);
        chk("done_single_pulse", alu_done, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        vec_t v, v2;
        int   bc, seen0, e0;

        //          dt    op     a      b      res    rem    ovf   dbz   lat
        vecs[0]  = '{1'b0, 2'd0, 8'd200, 8'd100, 8'h2C, 8'h00, 1'b1, 1'b0, 2};
        vecs[1]  = '{1'b1, 2'd1, 8'h80, 8'h01, 8'h7F, 8'h00, 1'b1, 1'b0, 2};
        vecs[2]  = '{1'b1, 2'd0, 8'h05, 8'hFD, 8'h02, 8'h00, 1'b0, 1'b0, 2};
        vecs[3]  = '{1'b0, 2'd1, 8'h03, 8'h05, 8'hFE, 8'h00, 1'b1, 1'b0, 2};
        vecs[4]  = '{1'b1, 2'd2, 8'hFD, 8'h05, 8'hF1, 8'h00, 1'b0, 1'b0, 9};
        vecs[5]  = '{1'b0, 2'd2, 8'h10, 8'h10, 8'h00, 8'h00, 1'b1, 1'b0, 9};
        vecs[6]  = '{1'b0, 2'd2, 8'h0F, 8'h0D, 8'hC3, 8'h00, 1'b0, 1'b0, 9};
        vecs[7]  = '{1'b1, 2'd2, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b1, 1'b0, 9};
        vecs[8]  = '{1'b0, 2'd3, 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 1'b0, 9};
        vecs[9]  = '{1'b1, 2'd3, 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 1'b0, 9};
        vecs[10] = '{1'b1, 2'd3, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b1, 1'b0, 9};
        vecs[11] = '{1'b1, 2'd3, 8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 1'b0, 9};
        vecs[12] = '{1'b0, 2'd3, 8'h05, 8'h00, 8'hFF, 8'h05, 1'b0, 1'b1, 2};
        vecs[13] = '{1'b0, 2'd0, 8'h01, 8'h02, 8'h03, 8'h00, 1'b0, 1'b0, 2};
        vecs[14] = '{1'b0, 2'd3, 8'hFF, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0, 9};
        vecs[15] = '{1'b1, 2'd3, 8'hFB, 8'h00, 8'hFF, 8'hFB, 1'b0, 1'b1, 2};

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_alu_done", alu_done, 1'b0);
        chk("rst_result", result, 8'h00);
        chk("rst_rem", rem, 8'h00);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_div_by_zero", div_by_zero, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 16; i++) run_vec(vecs[i]);

        // Start pulse during a running divide is dropped; exactly one completion follows.
        v     = '{1'b0, 2'd3, 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0, 9};
        seen0 = done_seen;
        start_op(v);
        @(negedge clk);
        a = 8'd1; b = 8'd1; op = 2'd0; parser_done = 1'b1;
        @(negedge clk);
        parser_done = 1'b0;
        chk("busy_after_ignored_start", busy, 1'b1);
        wait_done(40, bc);
        @(negedge clk);
        repeat (4) @(negedge clk);
        chk("single_done_count", done_seen - seen0, 1);

        // Reset mid-divide: everything returns to zero and no completion appears.
        v  = '{1'b1, 2'd3, 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 1'b0, 9};
        start_op(v);
        e0 = cyc;
        while (cyc < e0 + 3) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        seen0 = done_seen;
        @(negedge clk);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_alu_done", alu_done, 1'b0);
        chk("midrst_result", result, 8'h00);
        chk("midrst_rem", rem, 8'h00);
        chk("midrst_overflow", overflow, 1'b0);
        rst = 1'b0;
        repeat (W + 4) @(negedge clk);
        chk("midrst_no_done", done_seen - seen0, 0);

        // Back-to-back: new start presented in the alu_done cycle is accepted.
        v  = '{1'b0, 2'd0, 8'h10, 8'h20, 8'h30, 8'h00, 1'b0, 1'b0, 2};
        v2 = '{1'b0, 2'd2, 8'h03, 8'h07, 8'h15, 8'h00, 1'b0, 1'b0, 9};
        seen0 = done_seen;
        start_op(v);
        wait_done(40, bc);
        chk("b2b_first_done", alu_done, 1'b1);
        start_op(v2);
        chk("b2b_busy", busy, 1'b1);
        wait_done(40, bc);
        chk("b2b_busy_cycles", bc, W);
        @(negedge clk);
        chk("b2b_done_count", done_seen - seen0, 2);
        chk("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
